// File: rtl/fdivsqrt_wbbuf.sv
// Writeback result buffer behind the divide/sqrt FSM: captures one entry per DONE episode
// and presents the entries in FIFO order to the writeback arbiter.
module fdivsqrt_wbbuf #(
   parameter  int FLEN  = 64,
   parameter  int XLEN  = 64,
   parameter  int DEPTH = 2,
   localparam int RW    = (FLEN > XLEN) ? FLEN : XLEN,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            DoneE,
   input  logic [FLEN-1:0] FResE,
   input  logic [XLEN-1:0] IResE,
   input  logic [4:0]      FlagsE,
   input  logic [4:0]      RdE,
   input  logic            IntDivE,
   input  logic            FlushBuf,
   input  logic            WbGnt,
   output logic            WbValid,
   output logic [RW-1:0]   WbRes,
   output logic [4:0]      WbFlags,
   output logic [4:0]      WbRd,
   output logic            WbInt,
   output logic            BufFull,
   output logic [CW-1:0]   Count
);

   // Handshake: the head transfers on a cycle where WbValid and WbGnt are both high;
   // WbGnt without WbValid is ignored, and the head is stable while WbValid & ~WbGnt.
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          captured_q, captured_d;

   logic [RW-1:0] res_q   [DEPTH];
   logic [RW-1:0] res_d   [DEPTH];
   logic [4:0]    flags_q [DEPTH];
   logic [4:0]    flags_d [DEPTH];
   logic [4:0]    rd_q    [DEPTH];
   logic [4:0]    rd_d    [DEPTH];
   logic          int_q   [DEPTH];
   logic          int_d   [DEPTH];

   logic          wb_valid;
   logic          buf_full;
   logic          push;
   logic          pop;
   logic [RW-1:0] new_res;
   logic [4:0]    new_flags;

   always_comb begin
      wb_valid  = (count_q != '0);
      buf_full  = (count_q == CW'(DEPTH));
      pop       = wb_valid & WbGnt & ~FlushBuf;
      // A pop in the same cycle frees the slot, so a full buffer can still accept.
      push      = DoneE & ~captured_q & (~buf_full | (wb_valid & WbGnt)) & ~FlushBuf;
      new_res   = IntDivE ? RW'(IResE) : RW'(FResE);
      new_flags = IntDivE ? 5'b0 : FlagsE;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      captured_d = captured_q;
      if (FlushBuf) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         // An in-progress DONE episode is dropped, not captured after the flush.
         captured_d = DoneE;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (!DoneE)    captured_d = 1'b0;
         else if (push) captured_d = 1'b1;
      end
   end

   always_comb begin
      res_d   = res_q;
      flags_d = flags_q;
      rd_d    = rd_q;
      int_d   = int_q;
      if (push) begin
         res_d[wr_ptr_q]   = new_res;
         flags_d[wr_ptr_q] = new_flags;
         rd_d[wr_ptr_q]    = RdE;
         int_d[wr_ptr_q]   = IntDivE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         captured_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         captured_q <= captured_d;
      end
   end

   // Entry storage carries no reset; outputs are gated while the buffer is empty.
   always_ff @(posedge clk) begin
      res_q   <= res_d;
      flags_q <= flags_d;
      rd_q    <= rd_d;
      int_q   <= int_d;
   end

   always_comb begin
      WbValid = wb_valid;
      BufFull = buf_full;
      Count   = count_q;
      WbRes   = wb_valid ? res_q[rd_ptr_q]   : '0;
      WbFlags = wb_valid ? flags_q[rd_ptr_q] : '0;
      WbRd    = wb_valid ? rd_q[rd_ptr_q]    : '0;
      WbInt   = wb_valid ? int_q[rd_ptr_q]   : 1'b0;
   end

endmodule

// File: tb/tb_fdivsqrt_wbbuf.sv
// Bench for fdivsqrt_wbbuf: directed scenarios plus random traffic, all checked against
// a queue-based model of the buffer's capture/drain rules.
module tb_fdivsqrt_wbbuf;

   localparam int FLEN  = 64;
   localparam int XLEN  = 64;
   localparam int DEPTH = 2;
   localparam int EW    = 64 + 5 + 5 + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        DoneE;
   logic [63:0] FResE;
   logic [63:0] IResE;
   logic [4:0]  FlagsE;
   logic [4:0]  RdE;
   logic        IntDivE;
   logic        FlushBuf;
   logic        WbGnt;
   logic        WbValid;
   logic [63:0] WbRes;
   logic [4:0]  WbFlags;
   logic [4:0]  WbRd;
   logic        WbInt;
   logic        BufFull;
   logic [1:0]  Count;

   int checks   = 0;
   int failures = 0;

   logic [EW-1:0] exp_q[$];
   bit            m_captured = 1'b0;

   fdivsqrt_wbbuf #(.FLEN(FLEN), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .DoneE    (DoneE),
      .FResE    (FResE),
      .IResE    (IResE),
      .FlagsE   (FlagsE),
      .RdE      (RdE),
      .IntDivE  (IntDivE),
      .FlushBuf (FlushBuf),
      .WbGnt    (WbGnt),
      .WbValid  (WbValid),
      .WbRes    (WbRes),
      .WbFlags  (WbFlags),
      .WbRd     (WbRd),
      .WbInt    (WbInt),
      .BufFull  (BufFull),
      .Count    (Count)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: one capture per DONE episode, FIFO drain, flush drops everything
   always @(posedge clk or negedge reset) begin
      bit m_pop, m_push;
      if (!reset) begin
         exp_q.delete();
         m_captured = 1'b0;
      end else if (FlushBuf) begin
         exp_q.delete();
         m_captured = DoneE;
      end else begin
         m_pop  = (exp_q.size() != 0) && WbGnt;
         m_push = DoneE && !m_captured && ((exp_q.size() < DEPTH) || m_pop);
         if (m_pop) void'(exp_q.pop_front());
         if (m_push)
            exp_q.push_back({(IntDivE ? IResE : FResE), (IntDivE ? 5'd0 : FlagsE), RdE, IntDivE});
         if (!DoneE)      m_captured = 1'b0;
         else if (m_push) m_captured = 1'b1;
      end
   end

   // scoreboard compare, every cycle on the inactive edge
   always @(negedge clk) begin
      logic [EW-1:0] head;
      bit            ev;
      ev   = (exp_q.size() != 0);
      head = ev ? exp_q[0] : '0;
      chk("WbValid", 64'(WbValid), 64'(ev));
      chk("BufFull", 64'(BufFull), 64'(exp_q.size() == DEPTH));
      chk("Count",   64'(Count),   64'(exp_q.size()));
      chk("WbRes",   WbRes,        head[74:11]);
      chk("WbFlags", 64'(WbFlags), 64'(head[10:6]));
      chk("WbRd",    64'(WbRd),    64'(head[5:1]));
      chk("WbInt",   64'(WbInt),   64'(head[0]));
   end

   // driver
   initial begin
      reset = 1'b0; DoneE = 1'b1; FResE = 64'h4000_0000_0000_0000; IResE = '0;
      FlagsE = 5'b00010; RdE = 5'd6; IntDivE = 1'b0; FlushBuf = 1'b0; WbGnt = 1'b0;

      // reset with DONE held high
      repeat (3) tick();
      chk("rst_valid", 64'(WbValid), 64'd0);
      chk("rst_full",  64'(BufFull), 64'd0);
      chk("rst_count", 64'(Count),   64'd0);
      reset = 1'b1;
      tick();
      chk("post_rst_valid", 64'(WbValid), 64'd1);
      chk("post_rst_rd",    64'(WbRd),    64'd6);
      DoneE = 1'b0; WbGnt = 1'b1;
      tick();

      // single FP result
      DoneE = 1'b1; FResE = 64'h3FF0_0000_0000_0000; FlagsE = 5'b00001; RdE = 5'd7;
      tick();
      chk("fp_valid", 64'(WbValid), 64'd1);
      chk("fp_res",   WbRes,        64'h3FF0_0000_0000_0000);
      chk("fp_flags", 64'(WbFlags), 64'd1);
      chk("fp_rd",    64'(WbRd),    64'd7);
      chk("fp_int",   64'(WbInt),   64'd0);
      DoneE = 1'b0;
      tick();
      chk("fp_drained", 64'(Count), 64'd0);

      // held DONE captures once
      WbGnt = 1'b0; DoneE = 1'b1; RdE = 5'd5;
      repeat (5) tick();
      chk("held_count", 64'(Count), 64'd1);
      DoneE = 1'b0;
      tick();
      DoneE = 1'b1; RdE = 5'd9;
      tick();
      chk("held2_count", 64'(Count),   64'd2);
      chk("held2_full",  64'(BufFull), 64'd1);

      // full back-pressure then simultaneous pop/push
      DoneE = 1'b0;
      tick();
      DoneE = 1'b1; RdE = 5'd3;
      repeat (4) tick();
      chk("bp_count", 64'(Count),   64'd2);
      chk("bp_full",  64'(BufFull), 64'd1);
      chk("bp_head",  64'(WbRd),    64'd5);
      WbGnt = 1'b1;
      tick();
      chk("pp_count", 64'(Count), 64'd2);
      chk("pp_head",  64'(WbRd),  64'd9);
      WbGnt = 1'b0;
      tick();
      chk("pp_nodup", 64'(Count), 64'd2);
      DoneE = 1'b0; WbGnt = 1'b1;
      tick();
      chk("pp_last", 64'(WbRd), 64'd3);
      tick();
      chk("pp_empty", 64'(Count), 64'd0);

      // integer result
      WbGnt = 1'b0; DoneE = 1'b1; IntDivE = 1'b1; IResE = 64'hFFFF_FFFF_FFFF_FFFF;
      FResE = 64'h1234_5678_9ABC_DEF0; FlagsE = 5'b11111; RdE = 5'd11;
      tick();
      chk("int_int",   64'(WbInt),   64'd1);
      chk("int_flags", 64'(WbFlags), 64'd0);
      chk("int_res",   WbRes,        64'hFFFF_FFFF_FFFF_FFFF);
      DoneE = 1'b0; IntDivE = 1'b0; WbGnt = 1'b1;
      tick();

      // flush with DONE in progress
      WbGnt = 1'b0; DoneE = 1'b1; RdE = 5'd1;
      tick();
      DoneE = 1'b0;
      tick();
      DoneE = 1'b1; RdE = 5'd2;
      tick();
      DoneE = 1'b0;
      tick();
      DoneE = 1'b1; RdE = 5'd4;
      tick();
      FlushBuf = 1'b1; WbGnt = 1'b1;
      tick();
      chk("fl_count", 64'(Count),   64'd0);
      chk("fl_valid", 64'(WbValid), 64'd0);
      FlushBuf = 1'b0; WbGnt = 1'b0;
      repeat (2) tick();
      chk("fl_nocap", 64'(Count), 64'd0);
      DoneE = 1'b0;
      tick();
      DoneE = 1'b1;
      tick();
      chk("fl_recap", 64'(Count), 64'd1);
      DoneE = 1'b0; WbGnt = 1'b1;
      tick();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         DoneE    = ($urandom_range(0, 3) != 0);
         FlushBuf = ($urandom_range(0, 29) == 0);
         WbGnt    = $urandom_range(0, 1);
         IntDivE  = $urandom_range(0, 1);
         FResE    = {$urandom, $urandom};
         IResE    = {$urandom, $urandom};
         FlagsE   = 5'($urandom_range(0, 31));
         RdE      = 5'($urandom_range(0, 31));
         tick();
      end

      // asynchronous reset with a full buffer
      FlushBuf = 1'b0; WbGnt = 1'b0; DoneE = 1'b1;
      tick();
      DoneE = 1'b0;
      tick();
      DoneE = 1'b1;
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("arst_count", 64'(Count),   64'd0);
      chk("arst_valid", 64'(WbValid), 64'd0);
      tick();
      reset = 1'b1; DoneE = 1'b0;
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fdivsqrt_wbbuf.md
Name: fdivsqrt_wbbuf

Overview:
- Result buffer directly downstream of the divide/sqrt state machine.
- Captures each completed divsqrt/integer-divide result, with its flags and destination register, in a small FIFO.
- Presents results one at a time to the writeback arbiter and back-pressures the FSM when full, so the FSM holds its DONE state.
- Guarantees exactly one capture per completed operation, even when DONE persists for several cycles.

Parameters:
- FLEN, 64, floating-point result width.
- XLEN, 64, integer result width.
- DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- DoneE  in  1  divsqrt done level; high for one or more cycles per operation.
- FResE  in  FLEN  floating-point result.
- IResE  in  XLEN  integer result.
- FlagsE  in  5  IEEE exception flags (NV,DZ,OF,UF,NX).
- RdE  in  5  destination register.
- IntDivE  in  1  result is integer; selects IRes and forces flags to 0.
- FlushBuf  in  1  synchronous discard of all entries and capture history.
- WbGnt  in  1  writeback arbiter accepts the head entry this cycle.
- WbValid  out  1  head entry valid.
- WbRes  out  max(FLEN,XLEN)  head result, zero-extended.
- WbFlags  out  5  head flags.
- WbRd  out  5  head destination.
- WbInt  out  1  head is an integer result.
- BufFull  out  1  no free entry; OR-ed into the FSM's StallM.
- Count  out  clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (reset==0, asynchronous): wr/rd pointers=0, Count=0, Captured=0.
  - Outputs: WbValid=0, BufFull=0, WbRes/WbFlags/WbRd/WbInt=0.
  - Entry storage is not reset; outputs are gated to 0 when WbValid=0.
- Captured flag:
  - Set when an entry is written.
  - Cleared in any cycle with DoneE=0.
- Push condition: DoneE & ~Captured & (~BufFull | Pop).
  - A push writes {result, flags, Rd, IntDivE} at wr_ptr and increments wr_ptr (wrapping modulo DEPTH).
- Result selection:
  - IntDivE=1: stored result = zero-extended IResE, flags = 0.
  - IntDivE=0: stored result = zero-extended FResE, flags = FlagsE.
- Pop condition: WbValid & WbGnt.
  - Increments rd_ptr (wrapping).
  - WbGnt with WbValid=0 is ignored.
- Latency: a result pushed in cycle N appears on WbValid/Wb* in cycle N+1. There is no combinational DoneE→WbValid path.
- Head outputs are combinational from entry[rd_ptr] and are stable while WbValid=1 and WbGnt=0.
- Count: +1 on push only, −1 on pop only, unchanged on both or neither.
  - WbValid = (Count!=0).
  - BufFull = (Count==DEPTH).
- Simultaneous push and pop when full is allowed: Count stays DEPTH and the head advances. BufFull still reads 1 in that cycle, so the FSM stalls one extra cycle.
- Full with DoneE=1, no pop: no push, Captured stays 0, and the capture occurs in the first cycle a pop frees an entry.
- DoneE held high after a push (FSM stalled by another source): no duplicate push.
- Back-to-back operations: DoneE must drop for at least one cycle between operations; this is guaranteed by the FSM passing through IDLE.
- FlushBuf (synchronous): pointers=0, Count=0, Captured=1 if DoneE=1 else 0.
  - Flush has priority over push and pop in the same cycle.
  - A DONE episode in progress during the flush is dropped.
- Entries are returned in strict FIFO order.
- No state is kept outside the pointers, Count and Captured.

Test Plan:
- Reset: hold reset=0 three cycles with DoneE=1 → WbValid=0, BufFull=0, Count=0. Release reset → push next edge, WbValid=1 the cycle after.
- Single FP result: DoneE high one cycle, FResE=0x3FF0000000000000, FlagsE=5'b00001, RdE=7, WbGnt=1 → next cycle WbValid=1, WbRes=0x3FF0000000000000, WbFlags=1, WbRd=7, WbInt=0. Following cycle Count=0.
- Held DONE: DoneE high five cycles, WbGnt=0 → Count=1 (exactly one entry). DoneE low one cycle, then high with RdE=9 → Count=2, BufFull=1.
- Full back-pressure: DEPTH=2 full, DoneE=1 with RdE=3, WbGnt=0 for four cycles → no push, BufFull=1. WbGnt=1 one cycle → pop and push in the same edge, Count=2, and the third result (Rd=3) drains last.
- Integer result: IntDivE=1, IResE=0xFFFFFFFFFFFFFFFF, FlagsE=5'b11111 → WbInt=1, WbFlags=0, WbRes=0xFFFFFFFFFFFFFFFF.
- Flush: two entries queued, DoneE=1 held, FlushBuf=1 for one cycle with WbGnt=1 → Count=0, WbValid=0, and no capture until DoneE falls and rises again.
